// File: rtl/exe_defs_pkg.sv
// exe_defs_pkg: shared ALU op codes, shift types and NZCV bit indices for the execute stage
package exe_defs_pkg;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/val2_generator.sv
// val2_generator: combinational ARM shifter operand (rotated immediate, memory offset or shifted Rm)
module val2_generator
  import exe_defs_pkg::*;
(
  input  logic        imm,
  input  logic        mem,
  input  logic [31:0] rm,
  input  logic [11:0] shift_operand,
  output logic [31:0] val2
);
  logic [31:0] imm32;
  logic [63:0] imm_rot;
  logic [63:0] rm_rot;
  logic [31:0] asr;
  logic [31:0] shifted;
  logic [4:0]  sh;
  logic [1:0]  ty;
  always_comb begin
    imm32   = {24'b0, shift_operand[7:0]};
    imm_rot = {imm32, imm32} >> {shift_operand[11:8], 1'b0};
    sh      = shift_operand[11:7];
    ty      = shift_operand[6:5];
    rm_rot  = {rm, rm} >> sh;
    // kept in its own statement so the ternary below cannot strip the signedness
    asr     = $unsigned($signed(rm) >>> sh);
    shifted = ty == SH_LSL ? rm << sh :
              ty == SH_LSR ? rm >> sh :
              ty == SH_ASR ? asr : rm_rot[31:0];
    val2    = imm ? imm_rot[31:0] : mem ? {20'b0, shift_operand} : shifted;
  end
endmodule

// File: rtl/exe_stage_unit.sv
// exe_stage_unit: execute stage with forwarding, Val2, ALU, NZCV register and EXE/MEM register
module exe_stage_unit
  import exe_defs_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                wb_en_in,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic [3:0]          exe_cmd,
  input  logic                s_in,
  input  logic                b_in,
  input  logic                imm,
  input  logic [WIDTH-1:0]    pc_in,
  input  logic [WIDTH-1:0]    val_rn,
  input  logic [WIDTH-1:0]    val_rm,
  input  logic [11:0]         shift_operand,
  input  logic [23:0]         signed_imm_24,
  input  logic [REG_ADDR-1:0] dest_in,
  input  logic [1:0]          sel_src1,
  input  logic [1:0]          sel_src2,
  input  logic [WIDTH-1:0]    fwd_mem_val,
  input  logic [WIDTH-1:0]    fwd_wb_val,
  output logic                wb_en_out,
  output logic                mem_r_en_out,
  output logic                mem_w_en_out,
  output logic [REG_ADDR-1:0] dest_out,
  output logic [WIDTH-1:0]    alu_res_out,
  output logic [WIDTH-1:0]    val_rm_out,
  output logic [3:0]          status_out,
  output logic                branch_taken,
  output logic [WIDTH-1:0]    branch_addr
);
  logic [WIDTH-1:0] op1, rm_f, val2, b_op, res;
  logic [WIDTH:0]   sum;
  logic             cin, is_sub, is_arith, v;
  logic [3:0]       nzcv;
  val2_generator u_val2 (
    .imm(imm),
    .mem(mem_r_en_in | mem_w_en_in),
    .rm(rm_f),
    .shift_operand(shift_operand),
    .val2(val2)
  );
  // subtraction is op1 + ~val2 + cin, so C reads as "no borrow" and SBC's -!C falls out of cin=C
  always_comb begin
    op1      = sel_src1 == 2'b01 ? fwd_mem_val : sel_src1 == 2'b10 ? fwd_wb_val : val_rn;
    rm_f     = sel_src2 == 2'b01 ? fwd_mem_val : sel_src2 == 2'b10 ? fwd_wb_val : val_rm;
    is_sub   = exe_cmd == CMD_SUB || exe_cmd == CMD_SBC;
    is_arith = is_sub || exe_cmd == CMD_ADD || exe_cmd == CMD_ADC;
    b_op     = is_sub ? ~val2 : val2;
    cin      = exe_cmd == CMD_ADD ? 1'b0 : exe_cmd == CMD_SUB ? 1'b1 : status_out[FLAG_C];
    sum      = {1'b0, op1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    v        = (op1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
    res      = exe_cmd == CMD_MOV ? val2 :
               exe_cmd == CMD_MVN ? ~val2 :
               is_arith ? sum[WIDTH-1:0] :
               exe_cmd == CMD_AND ? op1 & val2 :
               exe_cmd == CMD_ORR ? op1 | val2 :
               exe_cmd == CMD_EOR ? op1 ^ val2 : '0;
    nzcv     = {res[WIDTH-1], res == '0,
                is_arith ? sum[WIDTH] : status_out[FLAG_C],
                is_arith ? v : status_out[FLAG_V]};
  end
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      status_out   <= '0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      dest_out     <= dest_in;
      alu_res_out  <= res;
      val_rm_out   <= rm_f;
      if (s_in) status_out <= nzcv;
    end
  end
endmodule
